// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a 4-digit seven-segment display.
// Latency: load -> N_out takes 1 cycle (load in the wrap cycle) up to 4*TICK_DIV cycles.
// Backpressure: none; load is a single-cycle request and the last load before a wrap wins.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   value_in, load    - new 16-bit display value and its single-cycle capture strobe
//   digit_en          - per-digit enable, 0 keeps that anode dark
//   blink_en          - blanks all anodes during the blink phase of the frame counter
//   sel               - one-hot digit select for the downstream nibble selector
//   N_out             - frame-stable value for the nibble selector
//   an                - active-low anode drives
//   frame_done        - one-cycle pulse after each frame wrap
//   load_ack          - one-cycle pulse after N_out takes a new value
module display_scanner #(
  parameter int TICK_DIV   = 100000,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        blink_en,
  output logic [3:0]  sel,
  output logic [15:0] N_out,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        load_ack
);

  // TICK_DIV is at least 2, so the prescaler always needs at least one bit.
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_sel;
  logic [15:0]           r_n_out;
  logic [15:0]           r_pend;
  logic                  r_pend_v;
  logic [BLINK_LOG2-1:0] r_fcnt;
  logic                  r_frame_done;
  logic                  r_load_ack;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_upd;
  logic [15:0]           w_next_n;
  logic                  w_blank;
  logic [3:0]            w_an;

  // Slot boundary and frame boundary (last cycle of digit 3's slot).
  assign w_tick = (r_cnt == CNT_LAST);
  assign w_wrap = w_tick & r_sel[3];

  // A load arriving in the wrap cycle bypasses the pending buffer so it is
  // shown on the very next cycle rather than a whole frame later.
  assign w_upd    = w_wrap & (load | r_pend_v);
  assign w_next_n = load ? value_in : r_pend;

  assign w_blank = blink_en & r_fcnt[BLINK_LOG2-1];

  // Prescaler: one digit slot every TICK_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Ring counter: the only state is the rotating one-hot select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= 4'b0001;
    end else if (w_tick) begin
      r_sel <= {r_sel[2:0], r_sel[3]};
    end
  end

  // Pending buffer. The wrap consumes whatever is pending (or the bypassed
  // load), so the valid flag clears there even if a load coincides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      if (load) begin
        r_pend <= value_in;
      end
      if (w_wrap) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  // Displayed value changes only at frame boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_out <= '0;
    end else if (w_upd) begin
      r_n_out <= w_next_n;
    end
  end

  // Frame counter drives the blink phase from its MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
    end else if (w_wrap) begin
      r_fcnt <= r_fcnt + BLINK_LOG2'(1);
    end
  end

  // Registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_load_ack   <= w_upd;
    end
  end

  // Anode drive is combinational so digit_en/blink_en act mid-slot.
  always_comb begin
    w_an = 4'b1111;
    w_an = ~(r_sel & digit_en & {4{~w_blank}});
  end

  assign sel        = r_sel;
  assign N_out      = r_n_out;
  assign an         = reset ? 4'b1111 : w_an;
  assign frame_done = r_frame_done;
  assign load_ack   = r_load_ack;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int TD = 4;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'b1111;
  logic        blink_en = 1'b0;
  logic [3:0]  sel;
  logic [15:0] N_out;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_ack;

  display_scanner #(.TICK_DIV(TD), .BLINK_LOG2(BL)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .digit_en(digit_en), .blink_en(blink_en), .sel(sel), .N_out(N_out),
    .an(an), .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_val;
  bit          tb_pv = 1'b0;

  // Scoreboard: every load_ack must present the next queued value and
  // coincide with frame_done.
  always @(negedge clk) begin
    if (!reset && load_ack) begin
      ack_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: load_ack with N_out=%h, nothing queued", N_out);
      end else begin
        exp_val = exp_q.pop_front();
        tb_pv = 1'b0;
        if (N_out !== exp_val) begin
          errors++;
          $display("FAIL ack_value: N_out=%h want %h", N_out, exp_val);
        end
      end
      checks++;
      if (frame_done !== 1'b1) begin
        errors++;
        $display("FAIL ack_frame: frame_done=%b want 1 with load_ack", frame_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  // Load for one cycle; a load before the wrap replaces the still-pending one.
  task automatic drive_load(input logic [15:0] val);
    load = 1'b1;
    value_in = val;
    if (tb_pv) void'(exp_q.pop_back());
    exp_q.push_back(val);
    tb_pv = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    exp_q.delete();
    tb_pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL rst_sel: sel=%b want 0001", sel); end
    checks++; if (N_out !== 16'h0000) begin errors++; $display("FAIL rst_nout: N_out=%h want 0000", N_out); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an: an=%b want 1111", an); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: frame_done=%b want 0", frame_done); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: load_ack=%b want 0", load_ack); end
    reset = 1'b0;
    cyc = 0;
    digit_en = 4'b1111;
    blink_en = 1'b0;
    go_to(1);
    drive_load(16'h1111);
    go_to(25);
    checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL pre_rst_sel: sel=%b want 0100", sel); end
    checks++; if (N_out !== 16'h1111) begin errors++; $display("FAIL pre_rst_nout: N_out=%h want 1111", N_out); end
    reset = 1'b1;
    exp_q.delete();
    tb_pv = 1'b0;
    #1;
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL mid_rst_sel: sel=%b want 0001", sel); end
    checks++; if (N_out !== 16'h0000) begin errors++; $display("FAIL mid_rst_nout: N_out=%h want 0000", N_out); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_rst_an: an=%b want 1111", an); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    #1;
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rel_an: an=%b want 1110", an); end
    go_to(3);
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL rel_sel3: sel=%b want 0001", sel); end
    go_to(4);
    checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL rel_sel4: sel=%b want 0010", sel); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_sel;
    logic       exp_fd;
    do_reset();
    digit_en = 4'b1111;
    blink_en = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      go_to(c);
      exp_sel = 4'(1 << ((c / TD) % 4));
      exp_fd = (c == 16) || (c == 32);
      checks++; if (sel !== exp_sel) begin errors++; $display("FAIL rot_sel c=%0d: sel=%b want %b", c, sel, exp_sel); end
      checks++; if (an !== ~exp_sel) begin errors++; $display("FAIL rot_an c=%0d: an=%b want %b", c, an, ~exp_sel); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL rot_fd c=%0d: frame_done=%b want %b", c, frame_done, exp_fd); end
    end
  endtask

  task automatic test_deferred();
    int base;
    do_reset();
    base = ack_cnt;
    go_to(4);
    drive_load(16'hABCD);
    for (int c = 5; c <= 15; c++) begin
      go_to(c);
      checks++; if (N_out !== 16'h0000) begin errors++; $display("FAIL def_hold c=%0d: N_out=%h want 0000", c, N_out); end
    end
    go_to(16);
    checks++; if (N_out !== 16'hABCD) begin errors++; $display("FAIL def_nout: N_out=%h want abcd", N_out); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL def_ack: load_ack=%b want 1", load_ack); end
    go_to(31);
    checks++; if (ack_cnt - base !== 1) begin errors++; $display("FAIL def_ackcnt: acks=%0d want 1", ack_cnt - base); end
  endtask

  task automatic test_overwrite();
    int base;
    logic [15:0] want;
    do_reset();
    base = ack_cnt;
    go_to(1);
    drive_load(16'h1234);
    go_to(9);
    drive_load(16'h5678);
    for (int c = 10; c <= 32; c++) begin
      go_to(c);
      want = (c >= 16) ? 16'h5678 : 16'h0000;
      checks++; if (N_out !== want) begin errors++; $display("FAIL ovw_nout c=%0d: N_out=%h want %h", c, N_out, want); end
    end
    go_to(33);
    checks++; if (ack_cnt - base !== 1) begin errors++; $display("FAIL ovw_ackcnt: acks=%0d want 1", ack_cnt - base); end
  endtask

  task automatic test_coincident();
    int base;
    do_reset();
    base = ack_cnt;
    go_to(2);
    drive_load(16'h9999);
    go_to(15);
    drive_load(16'h00F0);
    checks++; if (N_out !== 16'h00F0) begin errors++; $display("FAIL coin_nout: N_out=%h want 00f0", N_out); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL coin_ack: load_ack=%b want 1", load_ack); end
    for (int c = 17; c <= 33; c++) begin
      go_to(c);
      checks++; if (N_out !== 16'h00F0) begin errors++; $display("FAIL coin_keep c=%0d: N_out=%h want 00f0", c, N_out); end
    end
    go_to(34);
    checks++; if (ack_cnt - base !== 1) begin errors++; $display("FAIL coin_ackcnt: acks=%0d want 1", ack_cnt - base); end
  endtask

  task automatic test_mask_blink();
    logic [3:0] want;
    int slot;
    int fc;
    do_reset();
    digit_en = 4'b0101;
    blink_en = 1'b1;
    for (int c = 0; c <= 67; c++) begin
      go_to(c);
      slot = (c / TD) % 4;
      fc = (c / (4 * TD)) % 4;
      if (fc >= 2) want = 4'b1111;
      else if (slot == 0) want = 4'b1110;
      else if (slot == 2) want = 4'b1011;
      else want = 4'b1111;
      checks++; if (an !== want) begin errors++; $display("FAIL blink_an c=%0d: an=%b want %b", c, an, want); end
    end
    // Live changes mid-slot (slot 0, unblanked frame).
    go_to(65);
    digit_en = 4'b0000;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL live_mask: an=%b want 1111", an); end
    digit_en = 4'b0101;
    #1;
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL live_unmask: an=%b want 1110", an); end
    // Slot 0 of a blanked frame: dropping blink_en lights the digit at once.
    go_to(96);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL live_blank: an=%b want 1111", an); end
    blink_en = 1'b0;
    #1;
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL live_unblank: an=%b want 1110", an); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_deferred();
    test_overwrite();
    test_coincident();
    test_mask_blink();
    step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d values never acknowledged, want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
